// File: rtl/imem_boot_loader.sv
// Boot loader for the writable instruction memory: packs a little-endian byte stream
// into 32-bit words, writes them from word 0 upward and holds the CPU until the load is finished.
module imem_boot_loader #(
    parameter int DEPTH = 64,
    parameter int CNT_W = 7
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             start,
    input  logic [CNT_W-1:0] load_len,
    input  logic             rx_valid,
    input  logic [7:0]       rx_data,
    output logic             rx_ready,
    output logic             imem_we,
    output logic [31:0]      imem_wAddr,
    output logic [31:0]      imem_wData,
    output logic             cpu_hold,
    output logic             busy,
    output logic             done,
    output logic             err,
    output logic [31:0]      csum
);

    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

    typedef enum logic [1:0] {
        S_IDLE,
        S_LOAD,
        S_WRITE,
        S_DONE
    } state_t;

    state_t           r_state;
    state_t           w_next;
    logic [CNT_W-1:0] r_len;
    logic [CNT_W-1:0] r_word_idx;
    logic [1:0]       r_byte_idx;
    logic [23:0]      r_shift;
    logic [31:0]      r_waddr;
    logic [31:0]      r_wdata;
    logic [31:0]      r_csum;
    logic             r_hold;
    logic             r_err;

    logic             w_len_bad;
    logic             w_len_zero;
    logic [CNT_W-1:0] w_word_inc;
    logic             w_word_last;
    logic             w_xfer;

    assign w_len_bad   = (load_len > DEPTH_C);
    assign w_len_zero  = (load_len == '0);
    assign w_word_inc  = r_word_idx + CNT_W'(1);
    assign w_word_last = (w_word_inc == r_len);
    assign w_xfer      = rx_valid & rx_ready;

    assign imem_wAddr = r_waddr;
    assign imem_wData = r_wdata;
    assign cpu_hold   = r_hold;
    assign err        = r_err;
    assign csum       = r_csum;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next   = r_state;
        rx_ready = 1'b0;
        imem_we  = 1'b0;
        busy     = 1'b0;
        done     = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (start && !w_len_bad) begin
                    w_next = w_len_zero ? S_DONE : S_LOAD;
                end
            end
            S_LOAD: begin
                rx_ready = 1'b1;
                busy     = 1'b1;
                if (rx_valid && (r_byte_idx == 2'd3)) begin
                    w_next = S_WRITE;
                end
            end
            S_WRITE: begin
                imem_we = 1'b1;
                busy    = 1'b1;
                w_next  = w_word_last ? S_DONE : S_LOAD;
            end
            S_DONE: begin
                done   = 1'b1;
                w_next = S_IDLE;
            end
            default: w_next = S_IDLE;
        endcase
    end

    // The write address/data registers are loaded with the last byte, so they are
    // already valid during the WRITE cycle and keep their value afterwards.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_len      <= '0;
            r_word_idx <= '0;
            r_byte_idx <= '0;
            r_shift    <= '0;
            r_waddr    <= '0;
            r_wdata    <= '0;
            r_csum     <= '0;
            r_hold     <= 1'b1;
            r_err      <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        if (w_len_bad) begin
                            r_err <= 1'b1;
                        end else begin
                            r_err <= 1'b0;
                            if (w_len_zero) begin
                                r_hold <= 1'b0;
                            end else begin
                                r_len      <= load_len;
                                r_csum     <= '0;
                                r_byte_idx <= '0;
                                r_word_idx <= '0;
                                r_hold     <= 1'b1;
                            end
                        end
                    end
                end
                S_LOAD: begin
                    if (w_xfer) begin
                        r_byte_idx <= r_byte_idx + 2'd1;
                        case (r_byte_idx)
                            2'd0: r_shift[7:0]   <= rx_data;
                            2'd1: r_shift[15:8]  <= rx_data;
                            2'd2: r_shift[23:16] <= rx_data;
                            default: begin
                                r_wdata <= {rx_data, r_shift};
                                r_waddr <= 32'({r_word_idx, 2'b00});
                            end
                        endcase
                    end
                end
                S_WRITE: begin
                    r_csum     <= r_csum ^ r_wdata;
                    r_word_idx <= w_word_inc;
                    if (w_word_last) begin
                        r_hold <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_imem_boot_loader.sv
// Randomised bench for imem_boot_loader: a driver feeds byte streams and records the
// expected memory writes and completion checksums; a monitor checks them as they appear.
module tb_imem_boot_loader;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        start;
    logic [6:0]  load_len;
    logic        rx_valid;
    logic [7:0]  rx_data;
    logic        rx_ready;
    logic        imem_we;
    logic [31:0] imem_wAddr;
    logic [31:0] imem_wData;
    logic        cpu_hold;
    logic        busy;
    logic        done;
    logic        err;
    logic [31:0] csum;

    imem_boot_loader #(.DEPTH(64), .CNT_W(7)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .start      (start),
        .load_len   (load_len),
        .rx_valid   (rx_valid),
        .rx_data    (rx_data),
        .rx_ready   (rx_ready),
        .imem_we    (imem_we),
        .imem_wAddr (imem_wAddr),
        .imem_wData (imem_wData),
        .cpu_hold   (cpu_hold),
        .busy       (busy),
        .done       (done),
        .err        (err),
        .csum       (csum)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] a;
        logic [31:0] d;
    } wr_t;

    wr_t         exp_wr[$];
    logic [31:0] exp_done[$];
    logic [7:0]  stim[$];
    logic [31:0] model_csum;
    int          checks = 0;
    int          errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // Monitor: every write strobe and done pulse must match the oldest expectation.
    always @(negedge clk) begin
        if (reset_n) begin
            if (imem_we) begin
                if (exp_wr.size() == 0) begin
                    check("unexpected_write", 32'd1, 32'd0);
                end else begin
                    wr_t e;
                    e = exp_wr.pop_front();
                    check("write_addr", imem_wAddr, e.a);
                    check("write_data", imem_wData, e.d);
                end
            end
            if (done) begin
                if (exp_done.size() == 0) begin
                    check("unexpected_done", 32'd1, 32'd0);
                end else begin
                    check("done_csum", csum, exp_done.pop_front());
                    check("done_cpu_hold", 32'(cpu_hold), 32'd0);
                    check("done_err", 32'(err), 32'd0);
                end
            end
        end
    end

    task automatic pulse_start(input logic [6:0] len);
        start    = 1'b1;
        load_len = len;
        @(posedge clk); #1;
        start    = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b, input int gap, input bit inj, output bit ok);
        for (int g = 0; g < gap; g++) begin
            rx_valid = 1'b0;
            rx_data  = 8'($urandom);
            start    = inj & 1'($urandom_range(0, 1));
            load_len = 7'($urandom_range(0, 127));
            @(posedge clk); #1;
        end
        start    = 1'b0;
        rx_valid = 1'b1;
        rx_data  = b;
        ok       = 1'b0;
        for (int t = 0; t < 50 && !ok; t++) begin
            @(negedge clk);
            if (rx_ready) ok = 1'b1;
            @(posedge clk); #1;
        end
        rx_valid = 1'b0;
        if (!ok) check("byte_accept_timeout", 32'd0, 32'd1);
    endtask

    task automatic do_load(input int len, input int gap_lo, input int gap_hi, input bit inj);
        logic [31:0] word;
        logic [31:0] cs;
        bit          ok;
        cs = '0;
        pulse_start(7'(len));
        for (int w = 0; w < len; w++) begin
            word = '0;
            for (int b = 0; b < 4; b++) begin
                send_byte(stim[w*4+b], $urandom_range(gap_lo, gap_hi), inj, ok);
                word[8*b +: 8] = stim[w*4+b];
            end
            exp_wr.push_back('{a: 32'(w * 4), d: word});
            cs ^= word;
            if (w == len - 1) exp_done.push_back(cs);
        end
        @(negedge clk);
        check("latency_we", 32'(imem_we), 32'd1);
        check("write_busy", 32'(busy), 32'd1);
        @(posedge clk); #1;
        // A start arriving in the DONE cycle must be ignored, even with a bad length.
        start    = 1'b1;
        load_len = 7'd100;
        @(negedge clk);
        check("latency_done", 32'(done), 32'd1);
        @(posedge clk); #1;
        start = 1'b0;
        @(negedge clk);
        check("idle_err", 32'(err), 32'd0);
        check("idle_busy", 32'(busy), 32'd0);
        check("idle_cpu_hold", 32'(cpu_hold), 32'd0);
        @(posedge clk); #1;
        model_csum = cs;
    endtask

    task automatic fill_random(input int nbytes);
        stim.delete();
        for (int i = 0; i < nbytes; i++) stim.push_back(8'($urandom));
    endtask

    task automatic fill_directed();
        logic [7:0] prog [8] = '{8'h13, 8'h00, 8'h00, 8'h00, 8'h93, 8'h00, 8'h10, 8'h00};
        stim.delete();
        for (int i = 0; i < 8; i++) stim.push_back(prog[i]);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, checks %0d", checks);
        $fatal(1);
    end

    initial begin
        bit ok;
        logic [31:0] w0;
        reset_n  = 1'b0;
        start    = 1'b0;
        load_len = '0;
        rx_valid = 1'b0;
        rx_data  = '0;
        model_csum = '0;
        repeat (3) @(posedge clk);
        #1 reset_n = 1'b1;
        @(negedge clk);
        check("rst_cpu_hold", 32'(cpu_hold), 32'd1);
        check("rst_rx_ready", 32'(rx_ready), 32'd0);
        check("rst_imem_we", 32'(imem_we), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_err", 32'(err), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_waddr", imem_wAddr, 32'd0);
        @(posedge clk); #1;

        fill_directed();
        do_load(2, 0, 0, 1'b0);
        check("directed_csum", csum, 32'h00100080);

        fill_directed();
        do_load(2, 3, 3, 1'b0);
        check("gap_csum", csum, 32'h00100080);

        for (int n = 0; n < 8; n++) begin
            int len;
            len = $urandom_range(1, 8);
            fill_random(len * 4);
            do_load(len, 0, 3, 1'b1);
        end

        pulse_start(7'd65);
        rx_valid = 1'b1;
        @(negedge clk);
        check("len65_err", 32'(err), 32'd1);
        check("len65_busy", 32'(busy), 32'd0);
        check("len65_rx_ready", 32'(rx_ready), 32'd0);
        check("len65_cpu_hold", 32'(cpu_hold), 32'd0);
        repeat (2) @(posedge clk);
        #1 rx_valid = 1'b0;

        exp_done.push_back(model_csum);
        pulse_start(7'd0);
        @(negedge clk);
        check("len0_done", 32'(done), 32'd1);
        check("len0_err", 32'(err), 32'd0);
        @(posedge clk); #1;

        fill_random(8);
        pulse_start(7'd3);
        w0 = '0;
        for (int b = 0; b < 6; b++) begin
            send_byte(stim[b], $urandom_range(0, 2), 1'b0, ok);
            if (b < 4) w0[8*b +: 8] = stim[b];
            if (b == 3) exp_wr.push_back('{a: 32'd0, d: w0});
        end
        #2 reset_n = 1'b0;
        #1;
        check("midrst_cpu_hold", 32'(cpu_hold), 32'd1);
        check("midrst_rx_ready", 32'(rx_ready), 32'd0);
        check("midrst_busy", 32'(busy), 32'd0);
        check("midrst_err", 32'(err), 32'd0);
        check("midrst_csum", csum, 32'd0);
        check("midrst_waddr", imem_wAddr, 32'd0);
        check("midrst_wdata", imem_wData, 32'd0);
        repeat (2) @(posedge clk);
        #1 reset_n = 1'b1;
        check("midrst_queue_drained", 32'(exp_wr.size()), 32'd0);

        fill_random(4);
        do_load(1, 0, 2, 1'b0);

        repeat (4) @(posedge clk);
        #1;
        check("end_writes_pending", 32'(exp_wr.size()), 32'd0);
        check("end_done_pending", 32'(exp_done.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
